// File: rtl/uart_rx.sv
// UART receiver: oversamples rxd on a synchronised bclkx8 tick, deserialises LSB-first frames
// and hands bytes to the host through a valid/ack handshake with framing/parity/overrun status.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | line idle, waiting for a low sample to mark a start bit
// START     | validating the start bit at mid-bit (false start -> IDLE)
// DATA      | shifting payload bits in, LSB first
// PARITY    | checking the parity bit against the received payload
// STOP      | sampling the stop bit; frame completes at mid-bit
// WAIT_HIGH | stop bit was low; hold off until the line returns high
module uart_rx #(
   parameter int unsigned DATA_BITS  = 8,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 bclkx8,
   input  logic                 rxd,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_err,
   output logic                 parity_err,
   output logic                 overrun_err
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PARITY    = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   // input synchronisers and bclkx8 edge detect
   logic rxd_meta_q, rxd_meta_d;
   logic rxd_s_q, rxd_s_d;
   logic bclk_meta_q, bclk_meta_d;
   logic bclk_sync_q, bclk_sync_d;
   logic bclk_last_q, bclk_last_d;
   logic tick;

   // receive FSM
   logic [2:0]           state_q, state_d;
   logic [2:0]           s_q, s_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]           samp_q, samp_d;
   logic                 par_err_pend_q, par_err_pend_d;
   logic                 frm_err_pend_q, frm_err_pend_d;
   logic                 done_q, done_d;
   logic                 maj;
   logic                 par_exp;

   // host-facing registers
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 framing_err_q, framing_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 overrun_err_q, overrun_err_d;

   always_comb begin
      rxd_meta_d  = rxd;
      rxd_s_d     = rxd_meta_q;
      bclk_meta_d = bclkx8;
      bclk_sync_d = bclk_meta_q;
      bclk_last_d = bclk_sync_q;
   end

   assign tick = bclk_sync_q & ~bclk_last_q;

   // the third sample is taken live on the s=5 tick
   assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s_q) | (samp_q[1] & rxd_s_q);
   assign par_exp = (^shift_q) ^ PARITY_ODD;

   always_comb begin
      state_d        = state_q;
      s_d            = s_q;
      bit_idx_d      = bit_idx_q;
      shift_d        = shift_q;
      samp_d         = samp_q;
      par_err_pend_d = par_err_pend_q;
      frm_err_pend_d = frm_err_pend_q;
      done_d         = 1'b0;

      if (tick) begin
         s_d = s_q + 3'd1;
         if (s_q == 3'd3) samp_d[0] = rxd_s_q;
         if (s_q == 3'd4) samp_d[1] = rxd_s_q;

         case (state_q)
            ST_IDLE: begin
               s_d = 3'd0;
               if (!rxd_s_q) begin
                  state_d        = ST_START;
                  s_d            = 3'd1;
                  par_err_pend_d = 1'b0;
               end
            end
            ST_START: begin
               if (s_q == 3'd5 && maj) begin
                  state_d = ST_IDLE;
                  s_d     = 3'd0;
               end else if (s_q == 3'd7) begin
                  state_d   = ST_DATA;
                  bit_idx_d = 3'd0;
               end
            end
            ST_DATA: begin
               if (s_q == 3'd5) shift_d = {maj, shift_q[DATA_BITS-1:1]};
               if (s_q == 3'd7) begin
                  if (bit_idx_q == LAST_IDX) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                  else                       bit_idx_d = bit_idx_q + 3'd1;
               end
            end
            ST_PARITY: begin
               if (s_q == 3'd5) par_err_pend_d = maj ^ par_exp;
               if (s_q == 3'd7) state_d = ST_STOP;
            end
            ST_STOP: begin
               if (s_q == 3'd5) begin
                  done_d         = 1'b1;
                  frm_err_pend_d = ~maj;
                  s_d            = 3'd0;
                  state_d        = maj ? ST_IDLE : ST_WAIT_HIGH;
               end
            end
            ST_WAIT_HIGH: begin
               s_d = 3'd0;
               if (rxd_s_q) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               s_d     = 3'd0;
            end
         endcase
      end
   end

   // a completing frame always wins over a pending one; ack in the same cycle only clears overrun
   always_comb begin
      rx_data_d     = rx_data_q;
      rx_valid_d    = rx_valid_q;
      framing_err_d = framing_err_q;
      parity_err_d  = parity_err_q;
      overrun_err_d = overrun_err_q;

      if (done_q) begin
         rx_data_d     = shift_q;
         framing_err_d = frm_err_pend_q;
         parity_err_d  = PARITY_EN & par_err_pend_q;
         rx_valid_d    = 1'b1;
         overrun_err_d = rx_valid_q & ~rx_ack;
      end else if (rx_ack && rx_valid_q) begin
         rx_valid_d    = 1'b0;
         overrun_err_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         rxd_meta_q     <= 1'b1;
         rxd_s_q        <= 1'b1;
         bclk_meta_q    <= 1'b0;
         bclk_sync_q    <= 1'b0;
         bclk_last_q    <= 1'b0;
         state_q        <= ST_IDLE;
         s_q            <= 3'd0;
         bit_idx_q      <= 3'd0;
         shift_q        <= '0;
         samp_q         <= 2'b00;
         par_err_pend_q <= 1'b0;
         frm_err_pend_q <= 1'b0;
         done_q         <= 1'b0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         framing_err_q  <= 1'b0;
         parity_err_q   <= 1'b0;
         overrun_err_q  <= 1'b0;
      end else begin
         rxd_meta_q     <= rxd_meta_d;
         rxd_s_q        <= rxd_s_d;
         bclk_meta_q    <= bclk_meta_d;
         bclk_sync_q    <= bclk_sync_d;
         bclk_last_q    <= bclk_last_d;
         state_q        <= state_d;
         s_q            <= s_d;
         bit_idx_q      <= bit_idx_d;
         shift_q        <= shift_d;
         samp_q         <= samp_d;
         par_err_pend_q <= par_err_pend_d;
         frm_err_pend_q <= frm_err_pend_d;
         done_q         <= done_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         framing_err_q  <= framing_err_d;
         parity_err_q   <= parity_err_d;
         overrun_err_q  <= overrun_err_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign framing_err = framing_err_q;
   assign parity_err  = parity_err_q;
   assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: channel 0 is 8N1, channel 1 is 8E1. A frame-level model predicts the
// host-visible registers; they are compared every cycle outside each frame's stop-bit window.
module tb_uart_rx;

   logic            sys_clk = 1'b0;
   logic            bclkx8  = 1'b0;
   logic            rst     = 1'b1;
   logic [1:0]      rxd     = 2'b11;
   logic [1:0]      rx_ack  = 2'b00;
   logic [1:0][7:0] rx_data_w;
   logic [1:0]      rx_valid_w, ferr_w, perr_w, ovr_w;

   int checks = 0;
   int passed = 0;

   logic [7:0] m_data  [2];
   logic       m_valid [2];
   logic       m_ferr  [2];
   logic       m_perr  [2];
   logic       m_ovr   [2];
   bit         busy    [2];
   bit         chk_en = 1'b0;
   bit         hold   = 1'b0;

   uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
      .sys_clk(sys_clk), .rst(rst), .bclkx8(bclkx8), .rxd(rxd[0]), .rx_ack(rx_ack[0]),
      .rx_data(rx_data_w[0]), .rx_valid(rx_valid_w[0]), .framing_err(ferr_w[0]),
      .parity_err(perr_w[0]), .overrun_err(ovr_w[0]));

   uart_rx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
      .sys_clk(sys_clk), .rst(rst), .bclkx8(bclkx8), .rxd(rxd[1]), .rx_ack(rx_ack[1]),
      .rx_data(rx_data_w[1]), .rx_valid(rx_valid_w[1]), .framing_err(ferr_w[1]),
      .parity_err(perr_w[1]), .overrun_err(ovr_w[1]));

   always #5 sys_clk = ~sys_clk;
   initial begin
      #3;
      forever #40 bclkx8 = ~bclkx8;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // outputs packed as {data, valid, framing, parity, overrun}
   always @(negedge sys_clk) begin
      if (chk_en && !hold) begin
         for (int c = 0; c < 2; c++) begin
            if (!busy[c])
               check(c == 0 ? "ch0 regs" : "ch1 regs",
                     {20'd0, rx_data_w[c], rx_valid_w[c], ferr_w[c], perr_w[c], ovr_w[c]},
                     {20'd0, m_data[c], m_valid[c], m_ferr[c], m_perr[c], m_ovr[c]});
         end
      end
   end

   task automatic model_clear();
      for (int c = 0; c < 2; c++) begin
         m_data[c] = 8'd0; m_valid[c] = 1'b0; m_ferr[c] = 1'b0; m_perr[c] = 1'b0; m_ovr[c] = 1'b0;
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) @(posedge bclkx8);
   endtask

   task automatic send_bit(input int c, input logic b);
      rxd[c] = b;
      wait_ticks(8);
   endtask

   task automatic idle_bits(input int c, input int n);
      rxd[c] = 1'b1;
      wait_ticks(8 * n);
   endtask

   // leaves rxd at the stop value; a low stop must be followed by the caller raising the line
   task automatic send_frame(input int c, input logic [7:0] d, input logic par, input logic stop);
      @(posedge bclkx8);
      send_bit(c, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(c, d[i]);
      if (c == 1) send_bit(c, par);
      busy[c] = 1'b1;
      send_bit(c, stop);
      m_ovr[c]   = m_valid[c];
      m_valid[c] = 1'b1;
      m_data[c]  = d;
      m_ferr[c]  = ~stop;
      m_perr[c]  = (c == 1) ? (par != ^d) : 1'b0;
      busy[c]    = 1'b0;
   endtask

   task automatic ack(input int c);
      @(posedge sys_clk);
      #1 rx_ack[c] = 1'b1;
      @(posedge sys_clk);
      #1 rx_ack[c] = 1'b0;
      if (m_valid[c]) begin
         m_valid[c] = 1'b0;
         m_ovr[c]   = 1'b0;
      end
   endtask

   initial begin
      logic [7:0] d;
      logic       stop, par;
      int         c;

      model_clear();
      busy[0] = 1'b0;
      busy[1] = 1'b0;
      repeat (4) @(posedge sys_clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge sys_clk);
      check("reset valid", {30'd0, rx_valid_w}, 32'd0);
      check("reset data", {16'd0, rx_data_w}, 32'd0);

      // basic 8N1 frame and ack
      send_frame(0, 8'hA5, 1'b0, 1'b1);
      check("a5 data", {24'd0, rx_data_w[0]}, 32'hA5);
      check("a5 flags", {28'd0, rx_valid_w[0], ferr_w[0], perr_w[0], ovr_w[0]}, 32'b1000);
      ack(0);
      check("a5 ack valid", {31'd0, rx_valid_w[0]}, 32'd0);

      // false start
      @(posedge bclkx8);
      rxd[0] = 1'b0;
      wait_ticks(2);
      rxd[0] = 1'b1;
      wait_ticks(24);
      check("false start valid", {31'd0, rx_valid_w[0]}, 32'd0);

      // framing error, long break, then recovery
      send_frame(0, 8'h3C, 1'b0, 1'b0);
      wait_ticks(8 * 20);
      check("3c data", {24'd0, rx_data_w[0]}, 32'h3C);
      check("3c framing", {30'd0, rx_valid_w[0], ferr_w[0]}, 32'b11);
      idle_bits(0, 2);
      ack(0);
      send_frame(0, 8'h55, 1'b0, 1'b1);
      check("55 data", {24'd0, rx_data_w[0]}, 32'h55);
      check("55 framing", {31'd0, ferr_w[0]}, 32'd0);
      ack(0);

      // overrun on back-to-back frames
      send_frame(0, 8'h11, 1'b0, 1'b1);
      send_frame(0, 8'h22, 1'b0, 1'b1);
      check("overrun data", {24'd0, rx_data_w[0]}, 32'h22);
      check("overrun flags", {30'd0, rx_valid_w[0], ovr_w[0]}, 32'b11);
      ack(0);
      check("overrun cleared", {30'd0, rx_valid_w[0], ovr_w[0]}, 32'b00);

      // even parity on channel 1: 0x07 has odd weight, so the correct bit is 1
      send_frame(1, 8'h07, 1'b0, 1'b1);
      check("parity bad", {31'd0, perr_w[1]}, 32'd1);
      ack(1);
      send_frame(1, 8'h07, 1'b1, 1'b1);
      check("parity good", {31'd0, perr_w[1]}, 32'd0);
      check("parity data", {24'd0, rx_data_w[1]}, 32'h07);

      // reset mid-frame with a frame pending
      @(posedge bclkx8);
      send_bit(0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
      hold = 1'b1;
      @(posedge sys_clk);
      #1 rst = 1'b1;
      @(posedge sys_clk);
      #1 rst = 1'b0;
      model_clear();
      hold = 1'b0;
      rxd[0] = 1'b1;
      check("mid reset valid", {30'd0, rx_valid_w}, 32'd0);
      check("mid reset data", {16'd0, rx_data_w}, 32'd0);
      check("mid reset errs", {26'd0, ferr_w, perr_w, ovr_w}, 32'd0);
      idle_bits(0, 2);
      send_frame(0, 8'h5A, 1'b0, 1'b1);
      check("5a data", {24'd0, rx_data_w[0]}, 32'h5A);
      check("5a flags", {28'd0, rx_valid_w[0], ferr_w[0], perr_w[0], ovr_w[0]}, 32'b1000);

      // randomized traffic on both channels
      for (int n = 0; n < 40; n++) begin
         c    = int'($urandom_range(0, 1));
         d    = 8'($urandom);
         stop = ($urandom_range(0, 7) != 0);
         par  = (^d) ^ ($urandom_range(0, 3) == 0);
         send_frame(c, d, par, stop);
         if (!stop) idle_bits(c, 1);
         idle_bits(c, int'($urandom_range(0, 2)));
         if ($urandom_range(0, 2) == 0) ack(c);
         if ($urandom_range(0, 4) == 0) ack(1 - c);
      end
      idle_bits(0, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
